// File: rtl/audio_pkg.sv
// Shared frame geometry for the I2S speaker path.
// One frame is FRAME_LEN clk: 32 SCK slots of 16 clk each.
package audio_pkg;

    localparam int CNT_W       = 9;
    localparam int FRAME_LEN   = 512;
    localparam int SAMPLE_W    = 16;
    localparam int SLOT_W      = 5;
    localparam int CAPTURE_CNT = 511;

    // Slot k carries bit 32-k of {L,R}; modulo 32 that is simply -k.
    function automatic logic [SLOT_W-1:0] slot_bit_idx(input logic [SLOT_W-1:0] slot);
        return ~slot + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter with the I2S clocks decoded straight from its bits.
module i2s_clk_gen
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             mclk,
    output logic             sck,
    output logic             lrck
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign mclk = r_cnt[1];
    assign sck  = r_cnt[3];
    assign lrck = r_cnt[CNT_W-1];

endmodule

// File: rtl/speaker_ctrl.sv
// I2S transmitter: captures a stereo sample pair once per frame and shifts it out MSB first
// with the standard one-SCK delay after each LRCK edge.
module speaker_ctrl
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                sample_tick
);

    logic [CNT_W-1:0]      w_cnt;
    logic [SLOT_W-1:0]     w_slot;
    logic [SLOT_W-1:0]     w_next_slot;
    logic [2*SAMPLE_W-1:0] w_word;
    logic                  w_capture;
    logic                  w_slot_end;
    logic                  w_sdin_d;

    logic [SAMPLE_W-1:0]   r_left;
    logic [SAMPLE_W-1:0]   r_right;
    logic                  r_prev_lsb;
    logic                  r_sdin;

    i2s_clk_gen u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .cnt  (w_cnt),
        .mclk (audio_mclk),
        .sck  (audio_sck),
        .lrck (audio_lrck)
    );

    assign w_slot      = w_cnt[CNT_W-1 -: SLOT_W];
    assign w_next_slot = w_slot + SLOT_W'(1);
    assign w_slot_end  = &w_cnt[3:0];
    assign w_capture   = (w_cnt == CNT_W'(CAPTURE_CNT));
    assign w_word      = {r_left, r_right};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left     <= '0;
            r_right    <= '0;
            r_prev_lsb <= 1'b0;
        end else if (w_capture) begin
            r_left     <= mute ? '0 : audio_left;
            r_right    <= mute ? '0 : audio_right;
            r_prev_lsb <= r_right[0];
        end
    end

    // The capture edge is also the slot-0 edge, so slot 0 takes R[0] before it is replaced.
    always_comb begin
        w_sdin_d = r_sdin;
        if (w_slot_end) begin
            if (w_next_slot == '0) begin
                w_sdin_d = r_right[0];
            end else begin
                w_sdin_d = w_word[slot_bit_idx(w_next_slot)];
            end
        end else if (w_slot == '0) begin
            w_sdin_d = r_prev_lsb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdin <= 1'b0;
        end else begin
            r_sdin <= w_sdin_d;
        end
    end

    assign audio_sdin  = r_sdin;
    assign sample_tick = w_capture;

endmodule

// File: tb/tb_speaker_ctrl.sv
// Self-checking bench for speaker_ctrl: per-frame scoreboard of serialized slot bits,
// clock decode checks every cycle, and reset / clock-ratio sequences.
module tb_speaker_ctrl;

    typedef struct {
        int unsigned drive_at;
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        logic [31:0] exp_word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        mute = 1'b0;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        sample_tick;

    speaker_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .mute        (mute),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    // Bench-owned frame position, independent of the DUT counter.
    logic [8:0] tb_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= '0;
        else     tb_cnt <= tb_cnt + 9'd1;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] col = '0;
    logic        mon_en = 1'b0;
    logic [31:0] last_w = '0;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected slot bits of one frame: bit k = value on sdin during slot k.
    function automatic logic [31:0] frame_of(input logic [31:0] w, input logic p0);
        logic [31:0] f;
        f[0] = p0;
        for (int k = 1; k < 32; k++) f[k] = w[32-k];
        return f;
    endfunction

    task automatic wait_cnt(input int unsigned v);
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk);
            #1;
            if (tb_cnt == 9'(v)) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_cnt: cnt %0d not reached, got %0d", v, tb_cnt);
    endtask

    task automatic drain();
        for (int n = 0; n < 1100; n++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d frames still pending, expected 0", exp_q.size());
    endtask

    task automatic assert_reset(input string name);
        rst = 1'b1;
        #1;
        check(name, {27'b0, audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}, 32'h0);
    endtask

    task automatic hold_reset(input bit push_zero);
        repeat (3) @(negedge clk);
        exp_q.delete();
        last_w = '0;
        if (push_zero) exp_q.push_back(32'h0);
        mon_en = push_zero;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: clock decode and tick every cycle, slot bits mid-slot, frame compare at cnt 511.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("mclk", 32'(audio_mclk), 32'(tb_cnt[1]));
                check("sck", 32'(audio_sck), 32'(tb_cnt[3]));
                check("lrck", 32'(audio_lrck), 32'(tb_cnt[8]));
                check("sample_tick", 32'(sample_tick), 32'(tb_cnt == 9'd511));
                if (tb_cnt[3:0] == 4'd8) col[tb_cnt[8:4]] = audio_sdin;
                if (tb_cnt[3:0] == 4'd15)
                    check("sdin_stable", 32'(audio_sdin), 32'(col[tb_cnt[8:4]]));
                if (tb_cnt == 9'd511 && mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_underflow: got frame %h, expected none queued", col);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", col, e);
                    end
                end
            end
        end
    end

    initial begin
        int          n_mclk;
        int          n_sck;
        int          n_lrck;
        int          n_tick;
        logic        p_mclk;
        logic        p_sck;
        logic        p_lrck;

        tbl[0] = '{400, 16'h1234, 16'h5678, 1'b0, 32'h12345678};
        tbl[1] = '{300, 16'hA5C3, 16'h8001, 1'b0, 32'hA5C38001};
        tbl[2] = '{100, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFFFFFF};
        tbl[3] = '{100, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000000};
        tbl[4] = '{510, 16'h8000, 16'h7FFF, 1'b0, 32'h80007FFF};
        tbl[5] = '{3,   16'h7FFF, 16'h8000, 1'b0, 32'h7FFF8000};
        tbl[6] = '{250, 16'h0000, 16'h0001, 1'b0, 32'h00000001};
        tbl[7] = '{300, 16'hC0DE, 16'hBEEF, 1'b1, 32'h00000000};
        tbl[8] = '{300, 16'h0F0F, 16'hF0F0, 1'b0, 32'h0F0FF0F0};

        #3;
        assert_reset("rst_init");
        hold_reset(1'b0);

        // Clock ratios over 2048 clk, sampled at cnt 0..2048.
        n_mclk = 0; n_sck = 0; n_lrck = 0; n_tick = 0;
        p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
        for (int i = 0; i < 2049; i++) begin
            if (i > 0) @(negedge clk);
            if (audio_mclk != p_mclk) n_mclk++;
            if (audio_sck != p_sck)   n_sck++;
            if (audio_lrck != p_lrck) n_lrck++;
            if (sample_tick)          n_tick++;
            p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
        end
        check("mclk_toggles", 32'(n_mclk), 32'd1024);
        check("sck_toggles", 32'(n_sck), 32'd256);
        check("lrck_toggles", 32'(n_lrck), 32'd8);
        check("tick_pulses", 32'(n_tick), 32'd4);

        @(negedge clk);
        #2;
        assert_reset("rst_restart");
        hold_reset(1'b1);

        for (int i = 0; i < 9; i++) begin
            wait_cnt(2);
            audio_left  = 16'($urandom);
            audio_right = 16'($urandom);
            mute        = 1'($urandom_range(0, 1));
            wait_cnt(tbl[i].drive_at);
            audio_left  = tbl[i].l;
            audio_right = tbl[i].r;
            mute        = tbl[i].mute;
            exp_q.push_back(frame_of(tbl[i].exp_word, last_w[0]));
            last_w = tbl[i].exp_word;
        end
        drain();
        mon_en = 1'b0;

        // Reset in the middle of an all-ones frame.
        audio_left  = 16'hFFFF;
        audio_right = 16'hFFFF;
        mute        = 1'b0;
        wait_cnt(511);
        wait_cnt(200);
        check("pre_reset_sdin", 32'(audio_sdin), 32'd1);
        #3;
        assert_reset("rst_midframe");
        hold_reset(1'b1);
        exp_q.push_back(frame_of(32'hFFFFFFFF, 1'b0));
        drain();
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
